// File: rtl/seq_detect_p.sv
// rtl/seq_detect_p.sv - configurable serial pattern detector with saturating match counter
module seq_detect_p #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] PAT_W_L  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PAT_W:0]   ONE_EXT  = (PAT_W+1)'(1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [PAT_W-1:0] hist_sh;
    logic [LEN_W-1:0] fill_inc;
    logic [PAT_W:0]   mask_ext;
    logic [PAT_W-1:0] mask;
    logic             cfg_ok;
    logic             match;

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        out_d    = 1'b0;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        match    = 1'b0;

        hist_sh  = {hist_q[PAT_W-2:0], in};
        fill_inc = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_ONE;
        // Mask is one bit wider so len == PAT_W yields all ones without overflow
        mask_ext = (ONE_EXT << len_q) - ONE_EXT;
        mask     = mask_ext[PAT_W-1:0];
        cfg_ok   = (cfg_len != '0) && (cfg_len <= PAT_W_L);

        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                fill_d = '0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = hist_sh;
            fill_d = fill_inc;
            match  = (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);
            if (match) begin
                out_d = 1'b1;
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = match ? CNT_ONE : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_q  <= PAT_W'(3'b101);
            len_q  <= LEN_W'(3);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule
